cordic_float_ci: RTL and testbench

CORDIC_FLOAT_CI -- requirements
Module: cordic_float_ci

---
 rtl/cordic_pkg.sv | 33 +++
 rtl/cordic_ip.sv | 46 ++++
 rtl/cordic_float_ci.sv | 136 +++++++++++++
 tb/tb_cordic_float_ci.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the fixed-point cosine datapath.
// Holds the Q2.22 width constants, the CORDIC stage count, the arctangent
// table (atan(2^-i) scaled by 2^22, rounded), the aggregate gain
// compensation K_FIXED, and the sequencer state type.
`timescale 1ns/1ps
package cordic_pkg;

    localparam int FIXED_W       = 24;  // 1 sign, 1 int, 22 frac
    localparam int FRAC_W        = 22;
    localparam int GUARD_W       = 8;   // extra low bits carried through the rotations
    localparam int INT_W         = FIXED_W + GUARD_W;
    localparam int CORDIC_STAGES = 22;

    // 1/prod(sqrt(1+2^-2i)) over CORDIC_STAGES stages, Q2.22.
    localparam logic [FIXED_W-1:0] K_FIXED = 24'h26DD3B;

    localparam logic [FIXED_W-1:0] ATAN_TABLE [CORDIC_STAGES] = '{
        24'h3243F7, 24'h1DAC67, 24'h0FADBB, 24'h07F56F,
        24'h03FEAB, 24'h01FFD5, 24'h00FFFB, 24'h007FFF,
        24'h004000, 24'h002000, 24'h001000, 24'h000800,
        24'h000400, 24'h000200, 24'h000100, 24'h000080,
        24'h000040, 24'h000020, 24'h000010, 24'h000008,
        24'h000004, 24'h000002
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ROT  = 2'd2,
        PACK = 2'd3
    } cordic_state_e;

endpackage

// File: rtl/cordic_ip.sv
// Purely combinational rotation-mode CORDIC cosine core.
// Ports:
//   z   - signed Q2.22 angle in radians, |z| <= ~1.74
//   cos - signed Q2.22 cos(z)
// x/y are carried with GUARD_W extra fraction bits so the per-stage
// truncation of the arithmetic shifts does not accumulate into the output;
// the result is rounded back to Q2.22 at the end.
`timescale 1ns/1ps
module cordic_ip
    import cordic_pkg::*;
(
    input  logic [FIXED_W-1:0] z,
    output logic [FIXED_W-1:0] cos
);

    always_comb begin
        logic signed [INT_W-1:0]   x;
        logic signed [INT_W-1:0]   y;
        logic signed [INT_W-1:0]   xs;
        logic signed [INT_W-1:0]   ys;
        logic signed [FIXED_W-1:0] za;

        // Start on the x axis pre-scaled by K so no gain correction is needed.
        x  = signed'({K_FIXED, {GUARD_W{1'b0}}});
        y  = '0;
        xs = '0;
        ys = '0;
        za = signed'(z);
        for (int i = 0; i < CORDIC_STAGES; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (!za[FIXED_W-1]) begin
                x  = x - ys;
                y  = y + xs;
                za = za - signed'(ATAN_TABLE[i]);
            end else begin
                x  = x + ys;
                y  = y - xs;
                za = za + signed'(ATAN_TABLE[i]);
            end
        end
        // Round half up when dropping the guard bits.
        cos = FIXED_W'((x + (INT_W'(1) <<< (GUARD_W - 1))) >>> GUARD_W);
    end

endmodule

// File: rtl/cordic_float_ci.sv
// Single-precision cosine custom instruction.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   clk_en    - clock enable; every register holds while low
//   start     - request strobe, dataa valid in the same cycle
//   dataa     - IEEE-754 single angle in radians
//   done      - result strobe, result valid in the same cycle
//   result    - IEEE-754 single cos(dataa); holds between operations
//   state_dbg - current sequencer state (cordic_state_e encoding)
// Handshake: start is sampled only on an enabled edge while IDLE; starts in
// any other state or with clk_en low are dropped. done is high for exactly
// the PACK state, three enabled cycles after the accepted start, and result
// is valid while done is high.
// Pipeline: IDLE captures dataa, CONV converts it to clamped Q2.22, ROT
// registers the CORDIC cosine, PACK converts back to float.
`timescale 1ns/1ps
module cordic_float_ci
    import cordic_pkg::*;
#(
    parameter int          FRAC_BITS = 22,
    parameter logic [23:0] MAX_ANGLE = 24'h600000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  state_dbg
);

    cordic_state_e      state, state_nx;
    logic [31:0]        a_q;
    logic [FIXED_W-1:0] z_q;
    logic               nan_q;
    logic [FIXED_W-1:0] cos_q;
    logic [31:0]        result_q;

    logic [FIXED_W-1:0] mant24;
    logic [7:0]         shamt;
    logic [FIXED_W-1:0] mag;
    logic [FIXED_W-1:0] z_conv;
    logic               nan_conv;
    logic [FIXED_W-1:0] cos_core;
    logic [4:0]         msb;
    logic [FIXED_W-1:0] mant_sh;
    logic [31:0]        pack_val;

    // Float to Q2.22: the value is 1.m * 2^e, i.e. mant24 >> (23-FRAC_BITS-e).
    // Any e >= 1 is at least 2.0 and therefore always clamps.
    always_comb begin
        mant24   = {1'b1, a_q[22:0]};
        shamt    = 8'(127 + 23 - FRAC_BITS) - a_q[30:23];
        mag      = '0;
        nan_conv = 1'b0;
        if (a_q[30:23] == 8'hFF) begin
            nan_conv = 1'b1;
        end else if (a_q[30:23] == 8'h00 || a_q[30:23] < 8'(127 - FRAC_BITS)) begin
            mag = '0;
        end else if (a_q[30:23] >= 8'd128) begin
            mag = MAX_ANGLE;
        end else begin
            mag = mant24 >> shamt;
        end
        if (mag > MAX_ANGLE) begin
            mag = MAX_ANGLE;
        end
        z_conv = a_q[31] ? -mag : mag;
    end

    cordic_ip u_cordic_ip (
        .z   (z_q),
        .cos (cos_core)
    );

    // Q2.22 to float: exponent from the leading one, the bits below it
    // left-aligned into the mantissa (lossless, at most 22 of them).
    always_comb begin
        msb = '0;
        for (int i = 0; i < FIXED_W - 1; i++) begin
            if (cos_q[i]) begin
                msb = 5'(i);
            end
        end
        mant_sh  = cos_q << (5'd23 - msb);
        pack_val = '0;
        if (nan_q) begin
            pack_val = 32'h7FC00000;
        end else if (!cos_q[FIXED_W-1] && cos_q != '0) begin
            pack_val = {1'b0, 8'(127 - FRAC_BITS) + 8'(msb), mant_sh[22:0]};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CONV;
            CONV:    state_nx = ROT;
            ROT:     state_nx = PACK;
            PACK:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a_q      <= '0;
            z_q      <= '0;
            nan_q    <= 1'b0;
            cos_q    <= '0;
            result_q <= '0;
        end else if (clk_en) begin
            state <= state_nx;
            case (state)
                IDLE: if (start) a_q <= dataa;
                CONV: begin
                    z_q   <= z_conv;
                    nan_q <= nan_conv;
                end
                ROT:  cos_q <= cos_core;
                PACK: result_q <= pack_val;
                default: ;
            endcase
        end
    end

    // During PACK the freshly packed value is shown; afterwards the copy
    // captured on leaving PACK keeps result stable.
    assign done      = (state == PACK);
    assign result    = done ? pack_val : result_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_cordic_float_ci.sv
`timescale 1ns/1ps
module tb_cordic_float_ci;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic        done;
    logic [31:0] result;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    cordic_float_ci dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .start     (start),
        .dataa     (dataa),
        .done      (done),
        .result    (result),
        .state_dbg (state_dbg)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = e - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        if (b[31]) v = -v;
        return v;
    endfunction

    function automatic real absr(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Reference: cos of the angle clamped to +-1.5 rad; NaN/Inf give qNaN.
    function automatic real model_cos(input logic [31:0] a, output bit is_nan);
        real ang;
        is_nan = (a[30:23] == 8'hFF);
        ang = f2r(a);
        if (ang > 1.5)  ang = 1.5;
        if (ang < -1.5) ang = -1.5;
        return $cos(ang);
    endfunction

    localparam real TOL = 1.0 / 131072.0;  // 2^-17

    // ---------------- scoreboard model ----------------
    // cnt counts enabled edges left until the operation leaves its done cycle.
    logic [31:0] exp_q[$];
    int  cnt = 0;
    bit  have_res = 1'b0;
    bit  last_nan = 1'b0;
    real last_cos = 0.0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt = 0;
            exp_q.delete();
            have_res = 1'b0;
        end else if (clk_en) begin
            if (cnt > 0) begin
                if (cnt == 1 && exp_q.size() > 0) void'(exp_q.pop_front());
                cnt--;
            end else if (start) begin
                exp_q.push_back(dataa);
                cnt = 3;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_done;
        exp_done = rst && (cnt == 1);
        check("done", done == exp_done,
              $sformatf("t=%0t done=%0b required=%0b", $time, done, exp_done));
        if (exp_done && exp_q.size() > 0) begin
            last_cos = model_cos(exp_q[0], last_nan);
            have_res = 1'b1;
        end
        if (!have_res) begin
            check("result_idle", result == 32'h0,
                  $sformatf("t=%0t result=%h required=00000000", $time, result));
        end else if (last_nan) begin
            check("result_nan", result == 32'h7FC00000,
                  $sformatf("t=%0t result=%h required=7fc00000", $time, result));
        end else begin
            check("result_cos", !result[31] && absr(f2r(result) - last_cos) <= TOL,
                  $sformatf("t=%0t result=%h (%f) required=%f", $time, result, f2r(result), last_cos));
        end
    end

    // ---------------- driver ----------------
    // Issues one start and waits for done. stall: clk_en low for that many
    // cycles starting in ROT. dbl: a second start one cycle after the first.
    task automatic run_op(input logic [31:0] a, input int stall, input bit dbl,
                          output logic [31:0] res, output int lat);
        start = 1'b1;
        dataa = a;
        @(posedge clk); #1;
        start = 1'b0;
        dataa = $urandom;
        lat   = 1;
        if (dbl) begin
            start = 1'b1;
            dataa = 32'h3F000000;
        end
        while (!done && lat < 40) begin
            clk_en = !(stall > 0 && lat >= 2 && lat < 2 + stall);
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
        end
        clk_en = 1'b1;
        res    = result;
        check("done_timeout", done, $sformatf("no done within %0d cycles", lat));
        @(posedge clk); #1;
    endtask

    task automatic op_latency(input logic [31:0] a, input int stall, input bit dbl,
                              output logic [31:0] res);
        int lat;
        run_op(a, stall, dbl, res, lat);
        check("latency", lat == 3 + stall,
              $sformatf("dataa=%h latency=%0d required=%0d", a, lat, 3 + stall));
    endtask

    task automatic near(input string name, input logic [31:0] r, input real want);
        check(name, !r[31] && absr(f2r(r) - want) <= TOL,
              $sformatf("result=%h (%f) required=%f", r, f2r(r), want));
    endtask

    // ---------------- directed stimulus ----------------
    logic [31:0] sweep [8] = '{
        32'h00000001, 32'h33000000, 32'hBFC00000, 32'h3FBFFFFF,
        32'hFF800000, 32'h7FC00000, 32'h3FC00001, 32'hBE800000
    };

    initial begin
        logic [31:0] r;
        bit          n;
        int          dones;

        rst    = 1'b1;
        clk_en = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done",   done == 1'b0, $sformatf("done=%0b required=0", done));
        check("reset_result", result == 32'h0, $sformatf("result=%h required=00000000", result));
        check("reset_state",  state_dbg == 2'd0, $sformatf("state=%0d required=0", state_dbg));
        rst = 1'b1;
        @(posedge clk); #1;

        // Pin the reference model against hand values.
        check("model_cos1", absr(model_cos(32'h3F800000, n) - 0.540302) < 1.0e-5,
              $sformatf("model=%f required=0.540302", model_cos(32'h3F800000, n)));
        check("model_pi", absr(model_cos(32'h40490FDB, n) - 0.070737) < 1.0e-5,
              $sformatf("model=%f required=0.070737", model_cos(32'h40490FDB, n)));

        // cos(0) within 16 ULP of 1.0
        op_latency(32'h00000000, 0, 1'b0, r);
        check("cos0_ulp", (int'(r) - int'(32'h3F800000) <= 16) && (int'(32'h3F800000) - int'(r) <= 16),
              $sformatf("result=%h required=3f800000 +-16ulp", r));

        op_latency(32'h3F800000, 0, 1'b0, r);
        near("cos_p1", r, 0.540302);
        op_latency(32'hBF800000, 0, 1'b0, r);
        near("cos_m1", r, 0.540302);
        op_latency(32'h40490FDB, 0, 1'b0, r);
        near("cos_pi_clamp", r, 0.070737);
        op_latency(32'h7F800000, 0, 1'b0, r);
        check("cos_inf", r == 32'h7FC00000, $sformatf("result=%h required=7fc00000", r));

        // Second start one cycle later is dropped.
        op_latency(32'h3F800000, 0, 1'b1, r);
        near("dbl_start", r, 0.540302);
        check("dbl_single_pulse", done == 1'b0, $sformatf("done=%0b required=0", done));

        // Five stalled cycles in ROT.
        op_latency(32'h3E800000, 5, 1'b0, r);
        near("stall_result", r, 0.968912);

        // A start while clk_en is low is ignored.
        clk_en = 1'b0;
        start  = 1'b1;
        dataa  = 32'h00000000;
        @(posedge clk); #1;
        start  = 1'b0;
        clk_en = 1'b1;
        dones  = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("start_clk_en_low", dones == 0, $sformatf("done pulses=%0d required=0", dones));

        // Reset during CONV aborts the operation.
        start = 1'b1;
        dataa = 32'h3F800000;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("rst_abort_done",   done == 1'b0, $sformatf("done=%0b required=0", done));
        check("rst_abort_result", result == 32'h0, $sformatf("result=%h required=00000000", result));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        op_latency(32'h3F000000, 0, 1'b0, r);
        near("after_reset", r, 0.877583);

        // Boundary sweep: denormal, tiny, +-1.5 edges, NaN/Inf, negative angle.
        foreach (sweep[i]) begin
            op_latency(sweep[i], 0, 1'b0, r);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
